// File: rtl/ice40_io_pkg.sv
// Shared PIN_TYPE encodings for the iCE40 I/O cell model and the
// legality check used at elaboration.
package ice40_io_pkg;

   localparam logic [3:0] PIN_OUTPUT_NONE                         = 4'b0000;
   localparam logic [3:0] PIN_OUTPUT                              = 4'b0110;
   localparam logic [3:0] PIN_OUTPUT_REGISTERED                   = 4'b0101;
   localparam logic [3:0] PIN_OUTPUT_TRISTATE                     = 4'b1010;
   localparam logic [3:0] PIN_OUTPUT_REGISTERED_ENABLE            = 4'b1001;
   localparam logic [3:0] PIN_OUTPUT_REGISTERED_ENABLE_REGISTERED = 4'b1101;

   localparam logic [1:0] PIN_INPUT            = 2'b01;
   localparam logic [1:0] PIN_INPUT_REGISTERED = 2'b00;

   function automatic bit pin_type_legal(input logic [5:0] pin_type);
      bit out_ok;
      bit in_ok;
      case (pin_type[5:2])
         PIN_OUTPUT_NONE, PIN_OUTPUT, PIN_OUTPUT_REGISTERED,
         PIN_OUTPUT_TRISTATE, PIN_OUTPUT_REGISTERED_ENABLE,
         PIN_OUTPUT_REGISTERED_ENABLE_REGISTERED: out_ok = 1'b1;
         default:                                 out_ok = 1'b0;
      endcase
      in_ok = (pin_type[1:0] == PIN_INPUT) || (pin_type[1:0] == PIN_INPUT_REGISTERED);
      return out_ok && in_ok;
   endfunction

endpackage

// File: rtl/ice40_io_bit.sv
// Single-pin iCE40 I/O cell: output/enable/input registers plus the
// pad tristate driver selected by PIN_TYPE.
module ice40_io_bit
   import ice40_io_pkg::*;
#(
   parameter logic [5:0] PIN_TYPE = 6'b000000,
   parameter bit         PULLUP   = 1'b0
) (
   input  logic clk,
   input  logic resetq,
   inout  wire  package_pin,
   input  logic clock_enable,
   input  logic d_out_0,
   input  logic output_enable,
   output logic d_in_0
);

   localparam logic [3:0] OUT_MODE = PIN_TYPE[5:2];
   localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];

   logic out_p1;
   logic oe_p1;
   logic in_p1;
   logic drive_en;
   logic drive_val;

   // ---- register stage: output data, output enable, input capture ----
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         out_p1 <= 1'b0;
         oe_p1  <= 1'b0;
         in_p1  <= 1'b0;
      end else if (clock_enable) begin
         out_p1 <= d_out_0;
         oe_p1  <= output_enable;
         in_p1  <= package_pin;
      end
   end

   // ---- pad drive selection ----
   always_comb begin
      drive_en  = 1'b0;
      drive_val = 1'b0;
      case (OUT_MODE)
         PIN_OUTPUT: begin
            drive_en  = 1'b1;
            drive_val = d_out_0;
         end
         PIN_OUTPUT_REGISTERED: begin
            drive_en  = 1'b1;
            drive_val = out_p1;
         end
         PIN_OUTPUT_TRISTATE: begin
            drive_en  = output_enable;
            drive_val = d_out_0;
         end
         PIN_OUTPUT_REGISTERED_ENABLE: begin
            drive_en  = output_enable;
            drive_val = out_p1;
         end
         PIN_OUTPUT_REGISTERED_ENABLE_REGISTERED: begin
            drive_en  = oe_p1;
            drive_val = out_p1;
         end
         default: begin
            drive_en  = 1'b0;
            drive_val = 1'b0;
         end
      endcase
   end

   assign package_pin = drive_en ? drive_val : 1'bz;

   if (PULLUP) begin : g_pullup
      pullup pu (package_pin);
   end

   // Driving modes read back their own pad, which is how output state is observed.
   assign d_in_0 = (IN_MODE == PIN_INPUT) ? package_pin : in_p1;

endmodule

// File: rtl/ice40_io_cell.sv
// Vectorised iCE40 I/O cell: WIDTH single-pin cells sharing clock,
// reset, clock enable and PIN_TYPE.
module ice40_io_cell
   import ice40_io_pkg::*;
#(
   parameter logic [5:0] PIN_TYPE = 6'b000000,
   parameter int         WIDTH    = 1,
   parameter bit         PULLUP   = 1'b0
) (
   input  logic             clk,
   input  logic             resetq,
   inout  wire  [WIDTH-1:0] package_pin,
   input  logic             clock_enable,
   input  logic [WIDTH-1:0] d_out_0,
   input  logic [WIDTH-1:0] output_enable,
   output logic [WIDTH-1:0] d_in_0
);

   if (!pin_type_legal(PIN_TYPE)) begin : g_bad_pin_type
      $fatal(1, "ice40_io_cell: unsupported PIN_TYPE 6'b%06b", PIN_TYPE);
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      ice40_io_bit #(
         .PIN_TYPE (PIN_TYPE),
         .PULLUP   (PULLUP)
      ) u_bit (
         .clk           (clk),
         .resetq        (resetq),
         .package_pin   (package_pin[i]),
         .clock_enable  (clock_enable),
         .d_out_0       (d_out_0[i]),
         .output_enable (output_enable[i]),
         .d_in_0        (d_in_0[i])
      );
   end

endmodule

// File: tb/tb_ice40_io_cell.sv
// Directed bench for ice40_io_cell across the output and input modes,
// reset behaviour, clock enable and pull-up resolution.
module tb_ice40_io_cell;

   logic clk = 1'b0;
   logic resetq;
   logic clock_enable;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   // u1: registered output, combinational input
   logic d_out1, oe1;
   wire  pad1;
   logic d_in1;
   // u2: registered data, combinational enable, 8 pins, pull-up
   logic [7:0] d_out2, oe2;
   wire  [7:0] pad2;
   logic [7:0] d_in2;
   logic       ext2_en;
   logic [3:0] ext2_val;
   // u3: never drives, registered input, externally driven pad
   logic d_out3, oe3, ext3_val;
   wire  pad3;
   logic d_in3;
   // u4: registered data and enable, pull-up
   logic d_out4, oe4;
   wire  pad4;
   logic d_in4;
   // u5: never drives, pull-up
   logic d_out5, oe5;
   wire  pad5;
   logic d_in5;
   // u6: combinational output
   logic d_out6, oe6;
   wire  pad6;
   logic d_in6;
   // u7: combinational tristate, pull-up
   logic d_out7, oe7;
   wire  pad7;
   logic d_in7;

   assign pad2[7:4] = ext2_en ? ext2_val : 4'bzzzz;
   assign pad3      = ext3_val;

   ice40_io_cell #(.PIN_TYPE(6'b010101), .WIDTH(1), .PULLUP(1'b0)) u1 (
      .clk(clk), .resetq(resetq), .package_pin(pad1), .clock_enable(clock_enable),
      .d_out_0(d_out1), .output_enable(oe1), .d_in_0(d_in1));
   ice40_io_cell #(.PIN_TYPE(6'b100101), .WIDTH(8), .PULLUP(1'b1)) u2 (
      .clk(clk), .resetq(resetq), .package_pin(pad2), .clock_enable(clock_enable),
      .d_out_0(d_out2), .output_enable(oe2), .d_in_0(d_in2));
   ice40_io_cell #(.PIN_TYPE(6'b000000), .WIDTH(1), .PULLUP(1'b0)) u3 (
      .clk(clk), .resetq(resetq), .package_pin(pad3), .clock_enable(clock_enable),
      .d_out_0(d_out3), .output_enable(oe3), .d_in_0(d_in3));
   ice40_io_cell #(.PIN_TYPE(6'b110101), .WIDTH(1), .PULLUP(1'b1)) u4 (
      .clk(clk), .resetq(resetq), .package_pin(pad4), .clock_enable(clock_enable),
      .d_out_0(d_out4), .output_enable(oe4), .d_in_0(d_in4));
   ice40_io_cell #(.PIN_TYPE(6'b000001), .WIDTH(1), .PULLUP(1'b1)) u5 (
      .clk(clk), .resetq(resetq), .package_pin(pad5), .clock_enable(clock_enable),
      .d_out_0(d_out5), .output_enable(oe5), .d_in_0(d_in5));
   ice40_io_cell #(.PIN_TYPE(6'b011001), .WIDTH(1), .PULLUP(1'b0)) u6 (
      .clk(clk), .resetq(resetq), .package_pin(pad6), .clock_enable(clock_enable),
      .d_out_0(d_out6), .output_enable(oe6), .d_in_0(d_in6));
   ice40_io_cell #(.PIN_TYPE(6'b101001), .WIDTH(1), .PULLUP(1'b1)) u7 (
      .clk(clk), .resetq(resetq), .package_pin(pad7), .clock_enable(clock_enable),
      .d_out_0(d_out7), .output_enable(oe7), .d_in_0(d_in7));

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (pad1 !== 1'b0) begin n_fail++; $display("FAIL reset_pad1: got %b expected 0", pad1); end
      n_checks++; if (d_in1 !== 1'b0) begin n_fail++; $display("FAIL reset_din1: got %b expected 0", d_in1); end
      n_checks++; if (pad2 !== 8'hF0) begin n_fail++; $display("FAIL reset_pad2: got %h expected f0", pad2); end
      n_checks++; if (d_in3 !== 1'b0) begin n_fail++; $display("FAIL reset_din3: got %b expected 0", d_in3); end
      n_checks++; if (pad4 !== 1'b1) begin n_fail++; $display("FAIL reset_pad4_float: got %b expected 1", pad4); end
      #3 resetq = 1'b1;
   endtask

   task automatic test_registered_output();
      #1;
      n_checks++; if (pad1 !== 1'b0) begin n_fail++; $display("FAIL regout_before_edge: got %b expected 0", pad1); end
      @(posedge clk); #1;
      n_checks++; if (pad1 !== 1'b1) begin n_fail++; $display("FAIL regout_after_edge: got %b expected 1", pad1); end
      n_checks++; if (d_in1 !== 1'b1) begin n_fail++; $display("FAIL regout_readback: got %b expected 1", d_in1); end
      clock_enable = 1'b0;
      d_out1 = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (pad1 !== 1'b1) begin n_fail++; $display("FAIL regout_ce_hold: got %b expected 1", pad1); end
      clock_enable = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (pad1 !== 1'b0) begin n_fail++; $display("FAIL regout_ce_resume: got %b expected 0", pad1); end
   endtask

   task automatic test_tristate_enable();
      @(posedge clk); #1;
      n_checks++; if (pad2 !== 8'hF5) begin n_fail++; $display("FAIL tri_pad_low_nibble: got %h expected f5", pad2); end
      ext2_en  = 1'b1;
      ext2_val = 4'hC;
      #1;
      n_checks++; if (d_in2 !== 8'hC5) begin n_fail++; $display("FAIL tri_ext_drive: got %h expected c5", d_in2); end
      ext2_en = 1'b0;
      oe2     = 8'hF0;
      #1;
      n_checks++; if (d_in2 !== 8'hAF) begin n_fail++; $display("FAIL tri_comb_enable: got %h expected af", d_in2); end
   endtask

   task automatic test_registered_input();
      ext3_val = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (d_in3 !== 1'b0) begin n_fail++; $display("FAIL regin_low: got %b expected 0", d_in3); end
      ext3_val = 1'b1;
      #2;
      n_checks++; if (d_in3 !== 1'b0) begin n_fail++; $display("FAIL regin_between_edges: got %b expected 0", d_in3); end
      @(posedge clk); #1;
      n_checks++; if (d_in3 !== 1'b1) begin n_fail++; $display("FAIL regin_capture: got %b expected 1", d_in3); end
      clock_enable = 1'b0;
      ext3_val = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (d_in3 !== 1'b1) begin n_fail++; $display("FAIL regin_ce_hold: got %b expected 1", d_in3); end
      clock_enable = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (d_in3 !== 1'b0) begin n_fail++; $display("FAIL regin_ce_resume: got %b expected 0", d_in3); end
      ext3_val = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (d_in3 !== 1'b1) begin n_fail++; $display("FAIL regin_recapture: got %b expected 1", d_in3); end
      #2 resetq = 1'b0;
      #1;
      n_checks++; if (d_in3 !== 1'b0) begin n_fail++; $display("FAIL regin_async_reset: got %b expected 0", d_in3); end
      #1 resetq = 1'b1;
   endtask

   task automatic test_registered_enable();
      d_out4 = 1'b0;
      oe4    = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (pad4 !== 1'b1) begin n_fail++; $display("FAIL regoe_float: got %b expected 1", pad4); end
      oe4 = 1'b1;
      #1;
      n_checks++; if (pad4 !== 1'b1) begin n_fail++; $display("FAIL regoe_not_yet: got %b expected 1", pad4); end
      @(posedge clk); #1;
      n_checks++; if (pad4 !== 1'b0) begin n_fail++; $display("FAIL regoe_drive: got %b expected 0", pad4); end
      n_checks++; if (d_in4 !== 1'b0) begin n_fail++; $display("FAIL regoe_readback: got %b expected 0", d_in4); end
      oe4 = 1'b0;
      #1;
      n_checks++; if (pad4 !== 1'b0) begin n_fail++; $display("FAIL regoe_still_drive: got %b expected 0", pad4); end
      @(posedge clk); #1;
      n_checks++; if (pad4 !== 1'b1) begin n_fail++; $display("FAIL regoe_release: got %b expected 1", pad4); end
      oe4 = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (pad4 !== 1'b0) begin n_fail++; $display("FAIL regoe_redrive: got %b expected 0", pad4); end
      #2 resetq = 1'b0;
      #1;
      n_checks++; if (pad4 !== 1'b1) begin n_fail++; $display("FAIL regoe_async_reset: got %b expected 1", pad4); end
      resetq = 1'b1;
      #1;
      n_checks++; if (pad4 !== 1'b1) begin n_fail++; $display("FAIL regoe_after_release: got %b expected 1", pad4); end
      @(posedge clk); #1;
      n_checks++; if (pad4 !== 1'b0) begin n_fail++; $display("FAIL regoe_first_edge: got %b expected 0", pad4); end
   endtask

   task automatic test_pullup_and_comb();
      n_checks++; if (d_in5 !== 1'b1) begin n_fail++; $display("FAIL pullup_din: got %b expected 1", d_in5); end
      clock_enable = 1'b0;
      d_out6 = 1'b1;
      #1;
      n_checks++; if (d_in6 !== 1'b1) begin n_fail++; $display("FAIL comb_out_high: got %b expected 1", d_in6); end
      d_out6 = 1'b0;
      #1;
      n_checks++; if (pad6 !== 1'b0) begin n_fail++; $display("FAIL comb_out_low: got %b expected 0", pad6); end
      d_out7 = 1'b0;
      oe7    = 1'b1;
      #1;
      n_checks++; if (d_in7 !== 1'b0) begin n_fail++; $display("FAIL comb_tri_drive: got %b expected 0", d_in7); end
      oe7 = 1'b0;
      #1;
      n_checks++; if (d_in7 !== 1'b1) begin n_fail++; $display("FAIL comb_tri_float: got %b expected 1", d_in7); end
      clock_enable = 1'b1;
   endtask

   initial begin
      resetq       = 1'b0;
      clock_enable = 1'b1;
      d_out1 = 1'b1;  oe1 = 1'b0;
      d_out2 = 8'hA5; oe2 = 8'h0F; ext2_en = 1'b0; ext2_val = 4'h0;
      d_out3 = 1'b1;  oe3 = 1'b1;  ext3_val = 1'b1;
      d_out4 = 1'b0;  oe4 = 1'b1;
      d_out5 = 1'b0;  oe5 = 1'b0;
      d_out6 = 1'b0;  oe6 = 1'b0;
      d_out7 = 1'b1;  oe7 = 1'b0;

      test_reset();
      test_registered_output();
      test_tristate_enable();
      test_registered_input();
      test_registered_enable();
      test_pullup_and_comb();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
